// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI master arbiter: FSM state encoding and byte width.
package spi_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  // Scan candidates in rotated order; the first hit wins.
  always_comb begin : pick_p
    int               sum_v;
    logic [IDX_W-1:0] cand_v;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    sum_v  = 0;
    cand_v = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_v = int'(rr_ptr) + k;
      if (sum_v >= NUM_REQ) begin
        sum_v = sum_v - NUM_REQ;
      end else begin
        sum_v = sum_v;
      end
      cand_v = IDX_W'(sum_v);
      if (!any && req[cand_v]) begin
        any            = 1'b1;
        index          = cand_v;
        onehot[cand_v] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master byte engine; grants are locked per burst.
// Optional watchdog abort enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [BYTE_W-1:0]         rsp_data,
  output logic                      err,
  output logic                      m_start,
  output logic [BYTE_W-1:0]         m_data,
  input  logic [BYTE_W-1:0]         m_data_out,
  input  logic                      m_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_r, state_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic               last_q_r, last_q_s;
  logic [NUM_REQ-1:0] grant_r, grant_s;
  logic [NUM_REQ-1:0] req_ack_r, req_ack_s;
  logic [NUM_REQ-1:0] rsp_valid_r, rsp_valid_s;
  logic [BYTE_W-1:0]  rsp_data_r, rsp_data_s;
  logic               err_r, err_s;
  logic               m_start_r, m_start_s;
  logic [BYTE_W-1:0]  m_data_r, m_data_s;

  logic [NUM_REQ-1:0] pick_onehot_s;
  logic [IDX_W-1:0]   pick_index_s;
  logic               pick_any_s;
  logic               issue_s;
  logic [IDX_W-1:0]   issue_idx_s;
  logic [NUM_REQ-1:0] issue_onehot_s;
  logic               timeout_s;

  function automatic logic [IDX_W-1:0] advance_ptr(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .onehot (pick_onehot_s),
    .index  (pick_index_s),
    .any    (pick_any_s)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_r;

  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // Cycles spent in the current WAIT/HOLD visit; restarts on every state change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (state_s != state_r) begin
      cnt_r <= '0;
    end else if (state_r != IDLE) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYC > 0);
  assign timeout_s    = 1'b0;
`endif

  // In HOLD the owner is fixed, so the next byte bypasses arbitration.
  assign issue_idx_s    = (state_r == HOLD) ? idx_r   : pick_index_s;
  assign issue_onehot_s = (state_r == HOLD) ? grant_r : pick_onehot_s;

  // Next-state and next-output logic for all registered outputs.
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    idx_s       = idx_r;
    last_q_s    = last_q_r;
    grant_s     = grant_r;
    req_ack_s   = '0;
    rsp_valid_s = '0;
    rsp_data_s  = rsp_data_r;
    err_s       = 1'b0;
    m_start_s   = 1'b0;
    m_data_s    = m_data_r;
    issue_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          issue_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (m_done) begin
          rsp_data_s  = m_data_out;
          rsp_valid_s = grant_r;
          if (last_q_r) begin
            grant_s  = '0;
            rr_ptr_s = advance_ptr(idx_r);
            state_s  = IDLE;
          end else begin
            state_s = HOLD;
          end
        end else if (timeout_s) begin
          err_s    = 1'b1;
          grant_s  = '0;
          rr_ptr_s = advance_ptr(idx_r);
          state_s  = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (req[idx_r]) begin
          issue_s = 1'b1;
        end else if (timeout_s) begin
          err_s    = 1'b1;
          grant_s  = '0;
          rr_ptr_s = advance_ptr(idx_r);
          state_s  = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
      end
    endcase
    if (issue_s) begin
      grant_s   = issue_onehot_s;
      req_ack_s = issue_onehot_s;
      m_start_s = 1'b1;
      m_data_s  = req_data[int'(issue_idx_s)*BYTE_W +: BYTE_W];
      last_q_s  = req_last[issue_idx_s];
      idx_s     = issue_idx_s;
      state_s   = WAIT;
    end else begin
      state_s = state_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      idx_r       <= '0;
      last_q_r    <= 1'b0;
      grant_r     <= '0;
      req_ack_r   <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      err_r       <= 1'b0;
      m_start_r   <= 1'b0;
      m_data_r    <= '0;
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      idx_r       <= idx_s;
      last_q_r    <= last_q_s;
      grant_r     <= grant_s;
      req_ack_r   <= req_ack_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      err_r       <= err_s;
      m_start_r   <= m_start_s;
      m_data_r    <= m_data_s;
    end
  end

  assign grant     = grant_r;
  assign req_ack   = req_ack_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign err       = err_r;
  assign m_start   = m_start_r;
  assign m_data    = m_data_r;

endmodule
